fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pc  input  32  current PC register value.
REQ-006 imem_ready  input  1  instruction memory has valid data for pc this cycle.
REQ-007 stall_hz  input  1  hazard-unit stall request (load-use).
REQ-008 branch_taken  input  1  ID-stage branch resolved taken.
REQ-009 branch_target  input  32  branch destination.
REQ-010 jump  input  1  ID-stage jump.
REQ-011 jump_target  input  32  jump destination.
REQ-012 pc_next  output  32  value loaded into the PC register when stall_if=0.
REQ-013 stall_if  output  1  hold the PC register.
REQ-014 flush_id  output  1  squash the IF/ID instruction this cycle.
REQ-015 imem_req  output  1  instruction fetch request.
REQ-016 stall_count  output  CNT_W  saturating count of fetch-stalled cycles.

Function
REQ-017 FSM states SHALL be BOOT, RUN and WAIT_MEM; pending-redirect flag redir_pend and 32-bit register redir_pc SHALL be held alongside.
REQ-018 Outputs pc_next, stall_if, flush_id and imem_req SHALL be combinational from state, redir_pend, redir_pc and inputs; state, redir_pend, redir_pc and stall_count SHALL be registered.
REQ-019 Redirect SHALL be defined as jump OR branch_taken; redirect target SHALL be jump_target if jump=1, else branch_target (jump wins on simultaneous assertion).
REQ-020 BOOT: pc_next=RESET_VECTOR, stall_if=0, imem_req=0, flush_id=0; next state RUN unconditionally.
REQ-021 RUN: imem_req=1.
REQ-022 RUN, imem_ready=1, redirect=1: pc_next=target, stall_if=0, flush_id=1, regardless of stall_hz; stay RUN.
REQ-023 RUN, imem_ready=1, no redirect, stall_hz=1: stall_if=1, pc_next=pc, flush_id=0; stay RUN.
REQ-024 RUN, imem_ready=1, no redirect, stall_hz=0: pc_next=pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), stall_if=0; stay RUN.
REQ-025 RUN, imem_ready=0: stall_if=1, pc_next=pc; go WAIT_MEM; if redirect=1 in this cycle, load redir_pc=target and set redir_pend.
REQ-026 WAIT_MEM: imem_req=1, stall_if=1 while imem_ready=0; a redirect arriving here SHALL overwrite redir_pc and set redir_pend (latest redirect wins).
REQ-027 WAIT_MEM, imem_ready=1, redir_pend=1: pc_next=redir_pc, stall_if=0, flush_id=1, clear redir_pend, go RUN; a same-cycle redirect input SHALL take precedence over redir_pc.
REQ-028 WAIT_MEM, imem_ready=1, redir_pend=0: behave as REQ-022..REQ-024 for that cycle, then go RUN.
REQ-029 flush_id SHALL never assert in a cycle where stall_if=1.
REQ-030 stall_count SHALL increment by 1 on each clock edge where stall_if=1 and state is not BOOT, saturating at all-ones.

Reset
REQ-031 While rst=1: state<=BOOT, redir_pend<=0, redir_pc<=0, stall_count<=0 at the clock edge; combinational outputs SHALL be pc_next=RESET_VECTOR, stall_if=1, flush_id=0, imem_req=0.
REQ-032 rst asserted in WAIT_MEM with redir_pend=1 SHALL discard the pending redirect; first fetch after release is RESET_VECTOR.

Verification
REQ-033 Reset release, imem_ready=1 constant -> cycle 0 pc_next=0, then pc_next=4,8,12 with stall_if=0, stall_count=0.
REQ-034 pc=0x40, stall_hz=1 for 2 cycles -> stall_if=1, pc_next=0x40 both cycles, stall_count=2, then pc_next=0x44.
REQ-035 pc=0x40, imem_ready=1, jump=1 jump_target=0x100 and branch_taken=1 branch_target=0x200 -> pc_next=0x100, flush_id=1, stall_if=0.
REQ-036 pc=0x40, imem_ready=0 for 3 cycles, branch_taken=1 target=0x80 in 2nd cycle -> stall_if=1 for 3 cycles, then pc_next=0x80, flush_id=1.
REQ-037 pc=0xFFFF_FFFC, imem_ready=1 -> pc_next=0x0000_0000; 65540 forced stall cycles with CNT_W=16 -> stall_count=0xFFFF.
REQ-038 rst pulsed in WAIT_MEM with redir_pend=1 -> after release pc_next=RESET_VECTOR, flush_id=0, stall_count=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: chooses the next PC and stalls the PC register while
// memory is not ready, and holds any redirect that arrives during a stall until the fetch completes.
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    input  logic             imem_ready,
    input  logic             stall_hz,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    output logic [31:0]      pc_next,
    output logic             stall_if,
    output logic             flush_id,
    output logic             imem_req,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        WAIT_MEM = 2'd2
    } state_t;

    state_t           state;
    logic             redir_pend;
    logic [31:0]      redir_pc;
    logic [CNT_W-1:0] stall_count_reg;

    logic             redirect;
    logic [31:0]      redir_target;

    // Jump wins over a simultaneously resolved branch.
    assign redirect     = jump | branch_taken;
    assign redir_target = jump ? jump_target : branch_target;

    always_comb begin
        pc_next  = pc;
        stall_if = 1'b0;
        flush_id = 1'b0;
        imem_req = 1'b0;
        if (rst) begin
            pc_next  = RESET_VECTOR;
            stall_if = 1'b1;
        end else begin
            case (state)
                BOOT: begin
                    pc_next = RESET_VECTOR;
                end
                RUN, WAIT_MEM: begin
                    imem_req = 1'b1;
                    if (!imem_ready) begin
                        stall_if = 1'b1;
                    end else if (redirect) begin
                        // A live redirect outranks both a held one and a load-use stall.
                        pc_next  = redir_target;
                        flush_id = 1'b1;
                    end else if (state == WAIT_MEM && redir_pend) begin
                        pc_next  = redir_pc;
                        flush_id = 1'b1;
                    end else if (stall_hz) begin
                        stall_if = 1'b1;
                    end else begin
                        pc_next = pc + 32'd4;
                    end
                end
                default: begin
                    pc_next = RESET_VECTOR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            redir_pend <= 1'b0;
            redir_pc   <= 32'd0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (!imem_ready) begin
                        state <= WAIT_MEM;
                        if (redirect) begin
                            redir_pc   <= redir_target;
                            redir_pend <= 1'b1;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (!imem_ready) begin
                        // Latest redirect seen during the wait is the one that sticks.
                        if (redirect) begin
                            redir_pc   <= redir_target;
                            redir_pend <= 1'b1;
                        end
                    end else begin
                        state      <= RUN;
                        redir_pend <= 1'b0;
                    end
                end
                default: begin
                    state      <= BOOT;
                    redir_pend <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_reg <= '0;
        end else if (stall_if && state != BOOT && stall_count_reg != {CNT_W{1'b1}}) begin
            stall_count_reg <= stall_count_reg + CNT_W'(1);
        end
    end

    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// compared against a transaction-level model of the fetch rules.
module tb_fetch_ctrl;

    localparam int          CNT_W   = 16;
    localparam logic [31:0] RV      = 32'h0000_0000;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      pc;
    logic             imem_ready;
    logic             stall_hz;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic             jump;
    logic [31:0]      jump_target;
    logic [31:0]      pc_next;
    logic             stall_if;
    logic             flush_id;
    logic             imem_req;
    logic [CNT_W-1:0] stall_count;

    fetch_ctrl #(.RESET_VECTOR(RV), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .imem_ready   (imem_ready),
        .stall_hz     (stall_hz),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .pc_next      (pc_next),
        .stall_if     (stall_if),
        .flush_id     (flush_id),
        .imem_req     (imem_req),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: after-reset flag, outstanding-fetch flag, redirects remembered during a wait.
    bit          m_boot = 1'b1;
    bit          m_waiting = 1'b0;
    logic [31:0] m_pend_q[$];
    int          m_cnt = 0;
    bit          follow_pc = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already applied; compare outputs, advance the model, move to next negedge.
    task automatic step(input bit chk_en);
        logic [31:0] e_pc;
        logic        e_st, e_fl, e_rq;
        logic [31:0] tgt;
        bit          redir;
        #1;
        redir = jump || branch_taken;
        tgt   = jump ? jump_target : branch_target;
        e_pc = pc; e_st = 1'b0; e_fl = 1'b0; e_rq = 1'b0;
        if (rst) begin
            e_pc = RV; e_st = 1'b1;
        end else if (m_boot) begin
            e_pc = RV;
        end else begin
            e_rq = 1'b1;
            if (!imem_ready)                                 e_st = 1'b1;
            else if (redir)                   begin e_pc = tgt; e_fl = 1'b1; end
            else if (m_waiting && m_pend_q.size() > 0) begin e_pc = m_pend_q[$]; e_fl = 1'b1; end
            else if (stall_hz)                               e_st = 1'b1;
            else                                             e_pc = pc + 32'd4;
        end
        if (chk_en) begin
            chk("pc_next", pc_next, e_pc);
            chk("stall_if", 32'(stall_if), 32'(e_st));
            chk("flush_id", 32'(flush_id), 32'(e_fl));
            chk("imem_req", 32'(imem_req), 32'(e_rq));
            chk("stall_count", 32'(stall_count), 32'(m_cnt));
            chk("flush_while_stall", 32'(flush_id & stall_if), 32'd0);
        end
        if (rst) begin
            m_boot = 1'b1; m_waiting = 1'b0; m_pend_q.delete(); m_cnt = 0;
        end else begin
            if (!m_boot && e_st && m_cnt < CNT_MAX) m_cnt++;
            if (m_boot) m_boot = 1'b0;
            else if (!imem_ready) begin
                m_waiting = 1'b1;
                if (redir) m_pend_q.push_back(tgt);
            end else begin
                m_waiting = 1'b0;
                m_pend_q.delete();
            end
        end
        @(negedge clk);
        if (follow_pc && !e_st) pc = e_pc;
        $display("step rst=%0b rdy=%0b hz=%0b j=%0b b=%0b pc_next=%h stall=%0b flush=%0b cnt=%0d",
                 rst, imem_ready, stall_hz, jump, branch_taken, e_pc, e_st, e_fl, m_cnt);
    endtask

    task automatic idle_inputs();
        imem_ready = 1'b1; stall_hz = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = 32'd0; jump_target = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc = 32'd0;
        idle_inputs();
        @(negedge clk);

        // Power-up fetch sequence with memory always ready.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("boot_seq_pc", pc_next, 32'(k * 4));
            chk("boot_seq_stall", 32'(stall_if), 32'd0);
            step(1);
        end
        chk("boot_seq_cnt", 32'(stall_count), 32'd0);

        // Load-use stall for two cycles.
        do_reset();
        step(1);
        pc = 32'h40; stall_hz = 1'b1;
        #1; chk("hz_pc0", pc_next, 32'h40); chk("hz_st0", 32'(stall_if), 32'd1);
        step(1);
        #1; chk("hz_pc1", pc_next, 32'h40); chk("hz_st1", 32'(stall_if), 32'd1);
        step(1);
        stall_hz = 1'b0;
        #1; chk("hz_cnt", 32'(stall_count), 32'd2); chk("hz_after", pc_next, 32'h44);
        step(1);

        // Jump and branch together: jump wins.
        pc = 32'h40; jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h200;
        #1; chk("jb_pc", pc_next, 32'h100); chk("jb_flush", 32'(flush_id), 32'd1);
        chk("jb_stall", 32'(stall_if), 32'd0);
        step(1);
        idle_inputs();

        // Memory wait with a branch resolving mid-wait.
        pc = 32'h40; imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            branch_taken  = (k == 1);
            branch_target = 32'h80;
            #1; chk("mw_stall", 32'(stall_if), 32'd1);
            step(1);
        end
        idle_inputs();
        #1; chk("mw_pc", pc_next, 32'h80); chk("mw_flush", 32'(flush_id), 32'd1);
        step(1);

        // PC wrap at the top of the address space.
        pc = 32'hFFFF_FFFC;
        #1; chk("wrap_pc", pc_next, 32'h0000_0000);
        step(1);

        // Counter saturation.
        do_reset();
        step(1);
        stall_hz = 1'b1;
        for (int k = 0; k < 65540; k++) step(0);
        #1; chk("sat_cnt", 32'(stall_count), 32'h0000_FFFF);
        step(1);
        idle_inputs();

        // Reset while a redirect is pending in the memory wait.
        step(1);
        pc = 32'h300; imem_ready = 1'b0; jump = 1'b1; jump_target = 32'h500;
        step(1);
        jump = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0; idle_inputs();
        #1; chk("rstp_pc", pc_next, RV); chk("rstp_flush", 32'(flush_id), 32'd0);
        chk("rstp_cnt", 32'(stall_count), 32'd0);
        step(1);
        #1; chk("rstp_run_flush", 32'(flush_id), 32'd0);
        step(1);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            rst           = ($urandom_range(0, 59) == 0);
            imem_ready    = ($urandom_range(0, 3) != 0);
            stall_hz      = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 7) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            jump_target   = {$urandom(), 2'b00} >> 0;
            branch_target = {$urandom(), 2'b00} >> 0;
            if ($urandom_range(0, 9) == 0) pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
